mult_rr_scheduler: RTL and testbench
====================================

// Module: mult_rr_scheduler
// PURPOSE
//   Shares one 4x4 unsigned array multiplier (tt_um_array_multiplier_hhrb98) among
//   N_REQ requesters. Round-robin arbitration; valid/ready on both sides.
//   Sits between the requester ports and the multiplier datapath. Returns each
//   product tagged with the requester index.
// PARAMETERS
//   N_REQ  4  number of requesters, >=2
//   W      4  operand width; must match multiplier, product is 2*W
//   IDW    $clog2(N_REQ)  requester-index width (derived localparam)
// PORTS
//   clk        in   1          clock; all state updates on rising edge
//   rst_n      in   1          reset, synchronous, active-low
//   req_valid  in   N_REQ      per-requester operand valid
//   req_a      in   N_REQ*W    operand A, requester i at [i*W +: W]
//   req_b      in   N_REQ*W    operand B, same packing
//   req_ready  out  N_REQ      one-hot accept; transfer when valid & ready
//   rsp_valid  out  1          product valid
//   rsp_id     out  IDW        index of requester that owns rsp_p
//   rsp_p      out  2*W        unsigned product a*b
//   rsp_ready  in   1          consumer accepts response
//   busy       out  1          state != IDLE
//   ops_done   out  8          completed-response count, wraps 255->0
// BEHAVIOUR
//   Reset (rst_n low at edge, any state): state=IDLE, rr_ptr=N_REQ-1,
//     rsp_valid=0, rsp_id=0, rsp_p=0, ops_done=0, operand regs=0.
//     req_ready is forced to 0 while rst_n=0.
//   FSM: IDLE -> MUL -> OUT -> IDLE.
//   IDLE: grant = first valid index searching rr_ptr+1, rr_ptr+2, ... (mod N_REQ).
//     req_ready[grant]=1 combinationally. All other bits are 0.
//     If no req_valid, stay in IDLE with req_ready=0.
//     On transfer: latch a,b,grant into op_a, op_b, op_id; rr_ptr<=grant; go to MUL.
//   MUL: op_a/op_b drive the multiplier. At the edge, rsp_p<=product,
//     rsp_id<=op_id, rsp_valid<=1; go to OUT.
//   OUT: rsp_valid=1; rsp_id and rsp_p are held stable.
//     On rsp_ready: rsp_valid<=0, ops_done<=ops_done+1; go to IDLE.
//     Otherwise stay in OUT. This is backpressure with unbounded hold.
//   req_ready=0 in MUL and OUT. New requests are only accepted in IDLE.
//   Latency: accept edge -> rsp_valid high 2 edges later.
//     Minimum issue interval is 3 cycles (accept, mul, out with rsp_ready=1).
//   rr_ptr updates only on a grant. A requester whose valid drops before grant is
//     skipped. Requesters must hold valid and operands stable until ready
//     (protocol rule; the block does not check it).
//   Arithmetic: full 2*W unsigned product, no truncation or saturation.
//     15*15=225 fits in 8 bits.
//   Reset mid-operation: the in-flight op is discarded, no response is issued,
//     and ops_done is not incremented.
//   Simultaneous rsp_ready and new req_valid in OUT: the request waits one cycle
//     and is granted in the following IDLE.
// STRUCTURE
//   mult_sched_pkg: state encoding (IDLE=2'd0, MUL=2'd1, OUT=2'd2) and the
//     IDW helper (clog2).
//   Sub-module rr_arbiter:
//     - inputs: req vector, rr_ptr
//     - outputs: one-hot grant, grant index, any_grant
//     - purely combinational
//   Top module holds the FSM, operand/result registers, the counter, and one
//     multiplier instance.
// TESTING
//   1 Reset: hold rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0,
//     rsp_valid=0, busy=0, ops_done=0.
//   2 Single op: req_valid[2]=1, a=15, b=15 -> req_ready[2]=1 in IDLE cycle,
//     rsp_valid 2 edges later with rsp_id=2, rsp_p=225.
//   3 Fairness: all 4 valid continuously, rsp_ready=1 -> grant order
//     0,1,2,3,0, one response per 3 cycles. Operands a=i+1, b=3 -> p=3,6,9,12.
//   4 Backpressure: hold rsp_ready=0 for 5 cycles in OUT -> rsp_p and rsp_id
//     stable, all req_ready=0. Release -> ops_done increments by exactly 1.
//   5 Reset in MUL: pull rst_n low one edge -> next cycle IDLE, rsp_valid never
//     rises, ops_done unchanged. Requester 1 still valid -> re-granted first.
//   6 Edge values: a=0, b=9 -> p=0. Run 256 ops -> ops_done wraps to 0.

Source files
------------

// File: rtl/mult_rr_scheduler_pkg.sv
// Shared types for the round-robin multiplier scheduler: FSM encoding and
// the requester-index width helper.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    function automatic int idw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_array_mul.sv
// Unsigned W x W array multiplier: one shifted partial product added per row.
module mult_array #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [W:0][2*W-1:0] acc;

    assign acc[0] = '0;

    for (genvar i = 0; i < W; i++) begin : g_row
        assign acc[i+1] = acc[i] + (b[i] ? ({{W{1'b0}}, a} << i) : {2*W{1'b0}});
    end

    assign p = acc[W];

endmodule

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted req after rr_ptr, wrapping.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = idw_of(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        // rr_ptr itself is searched last, so the previous winner has lowest priority
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!any_grant && req[idx]) begin
                any_grant = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
        if (any_grant) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one array multiplier among N_REQ requesters with round-robin grant;
// each product returns tagged with the owning requester index.
module mult_rr_scheduler
    import mult_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    localparam int IDW  = idw_of(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [2*W-1:0]     rsp_p,
    input  logic               rsp_ready,
    output logic               busy,
    output logic [7:0]         ops_done
);

    state_e           state;
    logic [IDW-1:0]   rr_ptr;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [IDW-1:0]   op_id;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             any_grant;
    logic [2*W-1:0]   product;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    mult_array #(.W(W)) u_mul (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    // Gating on rst_n keeps requesters from seeing a transfer during reset.
    assign req_ready = (rst_n && state == S_IDLE) ? grant : '0;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= IDW'(N_REQ - 1);
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            ops_done  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_grant) begin
                        op_a   <= req_a[grant_idx*W +: W];
                        op_b   <= req_b[grant_idx*W +: W];
                        op_id  <= grant_idx;
                        rr_ptr <= grant_idx;
                        state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    rsp_p     <= product;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 8'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scenario bench for mult_rr_scheduler against a transaction-level model.
module tb_mult_rr_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [15:0]  req_a;
    logic [15:0]  req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [7:0]   rsp_p;
    logic         rsp_ready;
    logic         busy;
    logic [7:0]   ops_done;

    int tests = 0;
    int fails = 0;
    int last  = N - 1;  // model: most recently granted requester
    int model_ops = 0;

    always #5 clk = ~clk;

    mult_rr_scheduler #(.N_REQ(4), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    // Winner is the valid requester at the smallest forward distance past last.
    function automatic int pick(input logic [3:0] vm, input int lst);
        int best, bd, d;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            if (vm[i]) begin
                d = (i - lst - 1 + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic int prod(input logic [15:0] a, input logic [15:0] b, input int i);
        int ea, eb;
        ea = int'((a >> (i * 4)) & 16'hF);
        eb = int'((b >> (i * 4)) & 16'hF);
        return ea * eb;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last = N - 1;
        model_ops = 0;
    endtask

    // Presents vm until a grant, then follows the op to its response.
    task automatic run_op(input logic [3:0] vm, input logic [15:0] a, input logic [15:0] b,
                          input bit keep, output logic [3:0] rdy, output logic [1:0] id,
                          output logic [7:0] p, output int w, output int lat, output bit to);
        to = 1'b0; w = 0; lat = 0; id = '0; p = '0;
        req_valid = vm; req_a = a; req_b = b; rsp_ready = 1'b1;
        #1;
        while (req_ready == 4'b0 && w < 12) begin
            @(posedge clk); #1; w++;
        end
        rdy = req_ready;
        if (rdy == 4'b0) begin
            to = 1'b1;
            return;
        end
        @(posedge clk); #1; lat = 1;
        if (!keep) req_valid = vm & ~rdy;
        while (!rsp_valid && lat < 12) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) to = 1'b1;
        id = rsp_id;
        p  = rsp_p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (ops_done !== 8'd0) begin fails++; $display("FAIL reset_ops_done: got %0d want 0", ops_done); end
        req_valid = '0;
        rst_n = 1'b1;
        last = N - 1;
        model_ops = 0;
    endtask

    task automatic test_single();
        logic [3:0] rdy; logic [1:0] id; logic [7:0] p; int w, lat; bit to;
        run_op(4'b0100, 16'h0F00, 16'h0F00, 1'b0, rdy, id, p, w, lat, to);
        tests++; if (to || rdy !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", rdy); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL single_latency: got %0d want 2", lat); end
        tests++; if (id !== 2'd2 || p !== 8'd225) begin fails++; $display("FAIL single_rsp: got id=%0d p=%0d want id=2 p=225", id, p); end
        last = 2;
        model_ops++;
    endtask

    task automatic test_fairness();
        logic [3:0] rdy; logic [1:0] id; logic [7:0] p; int w, lat, e; bit to;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            e = pick(4'hF, last);
            run_op(4'hF, 16'h4321, 16'h3333, 1'b1, rdy, id, p, w, lat, to);
            tests++;
            if (to || rdy !== 4'(1 << e) || id !== 2'(e) || p !== 8'((e + 1) * 3)) begin
                fails++;
                $display("FAIL fair_op%0d: got rdy=%b id=%0d p=%0d want rdy=%b id=%0d p=%0d", k, rdy, id, p, 4'(1 << e), e, (e + 1) * 3);
            end
            tests++;
            if (lat !== 2 || w !== ((k == 0) ? 0 : 1)) begin
                fails++;
                $display("FAIL fair_timing%0d: got wait=%0d lat=%0d want wait=%0d lat=2", k, w, lat, (k == 0) ? 0 : 1);
            end
            last = e;
            model_ops++;
        end
    endtask

    task automatic test_backpressure();
        int e, ep, wt, e2;
        logic [15:0] a, b;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        model_ops = (model_ops > 0) ? model_ops : 0;
        a = 16'($urandom); b = 16'($urandom);
        req_valid = 4'b0010; req_a = a; req_b = b; rsp_ready = 1'b0;
        e = pick(4'b0010, last);
        ep = prod(a, b, e);
        #1; wt = 0;
        while (req_ready == 4'b0 && wt < 12) begin @(posedge clk); #1; wt++; end
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'hF;
        @(posedge clk); #1;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || rsp_p !== 8'(ep)) begin
            fails++; $display("FAIL bp_rsp: got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d", rsp_valid, rsp_id, rsp_p, e, ep);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || rsp_p !== 8'(ep) || req_ready !== 4'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d p=%0d rdy=%b busy=%b want v=1 id=%0d p=%0d rdy=0000 busy=1",
                         c, rsp_valid, rsp_id, rsp_p, req_ready, busy, e, ep);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        model_ops++;
        last = e;
        tests++;
        if (ops_done !== 8'(model_ops) || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release: got ops=%0d v=%b want ops=%0d v=0", ops_done, rsp_valid, model_ops % 256);
        end
        // Requests present across the release edge are granted only now, in IDLE.
        e2 = pick(4'hF, last);
        tests++; if (req_ready !== 4'(1 << e2)) begin fails++; $display("FAIL bp_next_grant: got %b want %b", req_ready, 4'(1 << e2)); end
        req_valid = '0;
    endtask

    task automatic test_reset_in_mul();
        logic [3:0] rdy; logic [1:0] id; logic [7:0] p; int w, lat, wt, e; bit to;
        logic [15:0] a, b;
        do_reset();
        a = 16'($urandom); b = 16'($urandom);
        req_valid = 4'b0110; req_a = a; req_b = b; rsp_ready = 1'b1;
        #1; wt = 0;
        while (req_ready == 4'b0 && wt < 12) begin @(posedge clk); #1; wt++; end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rmul_in_mul: got busy=%b v=%b want busy=1 v=0", busy, rsp_valid); end
        rst_n = 1'b0;
        #1;
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL rmul_ready_in_reset: got %b want 0000", req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last = N - 1;
        #1;
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || ops_done !== 8'(model_ops)) begin
            fails++; $display("FAIL rmul_after: got busy=%b v=%b ops=%0d want busy=0 v=0 ops=%0d", busy, rsp_valid, ops_done, model_ops);
        end
        e = pick(4'b0110, last);
        tests++; if (req_ready !== 4'(1 << e)) begin fails++; $display("FAIL rmul_regrant: got %b want %b", req_ready, 4'(1 << e)); end
        run_op(4'b0110, a, b, 1'b0, rdy, id, p, w, lat, to);
        tests++;
        if (to || id !== 2'(e) || p !== 8'(prod(a, b, e)) || lat !== 2) begin
            fails++; $display("FAIL rmul_op: got id=%0d p=%0d lat=%0d want id=%0d p=%0d lat=2", id, p, lat, e, prod(a, b, e));
        end
        last = e;
        model_ops++;
    endtask

    task automatic test_random();
        logic [3:0] rdy, vm; logic [1:0] id; logic [7:0] p; int w, lat, e; bit to;
        logic [15:0] a, b;
        for (int k = 0; k < 40; k++) begin
            vm = 4'($urandom_range(1, 15));
            a = 16'($urandom); b = 16'($urandom);
            e = pick(vm, last);
            run_op(vm, a, b, 1'b0, rdy, id, p, w, lat, to);
            tests++;
            if (to || rdy !== 4'(1 << e) || id !== 2'(e) || p !== 8'(prod(a, b, e)) || lat !== 2) begin
                fails++;
                $display("FAIL rand_op%0d: got rdy=%b id=%0d p=%0d lat=%0d want rdy=%b id=%0d p=%0d lat=2",
                         k, rdy, id, p, lat, 4'(1 << e), e, prod(a, b, e));
            end
            last = e;
            model_ops++;
        end
        @(posedge clk); #1;
        tests++; if (ops_done !== 8'(model_ops)) begin fails++; $display("FAIL rand_ops_done: got %0d want %0d", ops_done, model_ops % 256); end
    endtask

    task automatic test_wrap();
        logic [3:0] rdy, vm; logic [1:0] id; logic [7:0] p; int w, lat, e, bad; bit to;
        logic [15:0] a, b;
        do_reset();
        e = pick(4'b1000, last);
        run_op(4'b1000, 16'h0000, 16'h9000, 1'b0, rdy, id, p, w, lat, to);
        tests++; if (to || id !== 2'd3 || p !== 8'd0) begin fails++; $display("FAIL zero_operand: got id=%0d p=%0d want id=3 p=0", id, p); end
        last = e;
        model_ops++;
        bad = 0;
        for (int k = 0; k < 254; k++) begin
            vm = 4'($urandom_range(1, 15));
            a = 16'($urandom); b = 16'($urandom);
            e = pick(vm, last);
            run_op(vm, a, b, 1'b0, rdy, id, p, w, lat, to);
            if (to || id !== 2'(e) || p !== 8'(prod(a, b, e))) bad++;
            last = e;
            model_ops++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL wrap_ops: got %0d bad responses want 0", bad); end
        @(posedge clk); #1;
        tests++; if (ops_done !== 8'd255) begin fails++; $display("FAIL ops_done_255: got %0d want 255", ops_done); end
        run_op(4'b0001, 16'h000F, 16'h000F, 1'b0, rdy, id, p, w, lat, to);
        @(posedge clk); #1;
        model_ops++;
        tests++; if (to || p !== 8'd225 || ops_done !== 8'(model_ops)) begin fails++; $display("FAIL ops_done_wrap: got ops=%0d p=%0d want ops=0 p=225", ops_done, p); end
        req_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_in_mul();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
